// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit layout and transmitter state encoding for mmio_uart_tx.
package mmio_uart_pkg;

    localparam logic [1:0] OffData   = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffCtrl   = 2'd2;
    localparam logic [1:0] OffRsvd   = 2'd3;

    localparam int unsigned StatBusy   = 0;
    localparam int unsigned StatFull   = 1;
    localparam int unsigned StatEmpty  = 2;
    localparam int unsigned StatCntLsb = 3;
    localparam int unsigned StatCntMsb = 5;
    localparam int unsigned StatOvf    = 8;
    localparam int unsigned StatWidth  = 9;

    localparam int unsigned CntWidth  = StatCntMsb - StatCntLsb + 1;
    localparam int unsigned FrameBits = 8;
    localparam int unsigned MaxDepth  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    function automatic logic [StatWidth-1:0] pack_status(
        input logic                busy,
        input logic                full,
        input logic                empty,
        input logic [CntWidth-1:0] count,
        input logic                ovf
    );
        logic [StatWidth-1:0] s;
        s                        = '0;
        s[StatBusy]              = busy;
        s[StatFull]              = full;
        s[StatEmpty]             = empty;
        s[StatCntMsb:StatCntLsb] = count;
        s[StatOvf]               = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue for mmio_uart_tx. With MMIO_UART_TX_FIFO_EN defined it holds g_DEPTH
// entries; otherwise it collapses to a single holding register.
module uart_tx_fifo
    import mmio_uart_pkg::*;
#(
    parameter int unsigned g_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_push,
    input  logic [7:0]          i_data,
    input  logic                i_pop,
    output logic [7:0]          o_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [CntWidth-1:0] o_count
);

`ifdef MMIO_UART_TX_FIFO_EN
    localparam int unsigned Depth = g_DEPTH;
`else
    localparam int unsigned Depth = 1;
`endif
    localparam int unsigned PtrW = $clog2(MaxDepth);

    if (g_DEPTH == 0 || g_DEPTH > MaxDepth || (g_DEPTH & (g_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("uart_tx_fifo: g_DEPTH must be a power of 2 no larger than 4");
    end

    logic [7:0]          mem_q [MaxDepth];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Pointers wrap at the configured depth; entries above it are never addressed.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign o_full  = (count_q == CntWidth'(Depth));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(MaxDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_data;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a DATA/STATUS/CTRL register window.
// Define MMIO_UART_TX_FIFO_EN for a g_FIFO_DEPTH queue; default is one holding register.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int unsigned             g_ADDR_WIDTH   = 11,
    parameter int unsigned             g_DATA_WIDTH   = 9,
    parameter logic [g_ADDR_WIDTH-1:0] g_BASE_ADDR    = 11'h7F0,
    parameter int unsigned             g_CLKS_PER_BIT = 868,
    parameter int unsigned             g_FIFO_DEPTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [g_ADDR_WIDTH-1:0] i_addr,
    input  logic [g_DATA_WIDTH-1:0] i_data,
    output logic [g_DATA_WIDTH-1:0] o_data,
    output logic                    o_tx
);

    localparam int unsigned     BaudW    = (g_CLKS_PER_BIT > 1) ? $clog2(g_CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(g_CLKS_PER_BIT - 1);
    localparam int unsigned     BitW     = $clog2(FrameBits);

    logic                    sel;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [1:0]              off;
    logic                    data_wr;
    logic                    ctrl_clr;
    logic                    ovf_set;
    logic                    ovf_q, ovf_d;
    logic [g_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [StatWidth-1:0]    status;

    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CntWidth-1:0]     fifo_count;
    logic [7:0]              fifo_rdata;

    tx_state_e               state_q;
    logic [BaudW-1:0]        baud_q;
    logic [BitW-1:0]         bit_cnt_q;
    logic [7:0]              shift_q;
    logic                    tx_q;
    logic                    baud_end;

    logic                    unused_data;
    assign unused_data = ^i_data[g_DATA_WIDTH-1:8];

    // Bus decode: simultaneous read and write strobes are treated as no access.
    assign sel      = i_en && (i_addr[g_ADDR_WIDTH-1:2] == g_BASE_ADDR[g_ADDR_WIDTH-1:2]);
    assign off      = i_addr[1:0];
    assign wr_sel   = sel && i_we && !i_re;
    assign rd_sel   = sel && i_re && !i_we;
    assign data_wr  = wr_sel && (off == OffData);
    assign ctrl_clr = wr_sel && (off == OffCtrl) && i_data[0];

    assign baud_end = (baud_q == BaudLast);
    assign fifo_pop = !fifo_empty && ((state_q == StIdle) || (state_q == StStop && baud_end));
    assign ovf_set  = data_wr && fifo_full && !fifo_pop;

    uart_tx_fifo #(
        .g_DEPTH (g_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (data_wr),
        .i_data  (i_data[7:0]),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign status = pack_status(state_q != StIdle, fifo_full, fifo_empty, fifo_count, ovf_q);

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ctrl_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_sel) begin
            unique case (off)
                OffStatus: rdata_d = g_DATA_WIDTH'(status);
                OffData:   rdata_d = '0;
                OffCtrl:   rdata_d = '0;
                OffRsvd:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    // Serialiser: tx_q is updated together with the state so the line changes exactly
    // on bit boundaries.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    baud_q    <= '0;
                    bit_cnt_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= StStart;
                        shift_q <= fifo_rdata;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_cnt_q == BitW'(FrameBits - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= StStop;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            state_q <= StStart;
                            shift_q <= fifo_rdata;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
            endcase
        end
    end

    assign o_tx   = tx_q;
    assign o_data = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a transaction-level model predicts accepted bytes, STATUS and
// read data; a line monitor decodes o_tx frames and checks them against the byte queue.
module tb_mmio_uart_tx;

    localparam int unsigned Clks        = 4;
    localparam int          FrameCycles = 10 * Clks;
    localparam logic [10:0] BaseAddr    = 11'h7F0;
`ifdef MMIO_UART_TX_FIFO_EN
    localparam int Depth = 4;
`else
    localparam int Depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [10:0] addr = '0;
    logic [8:0]  wdata = '0;
    logic [8:0]  rdata;
    logic        tx;

    mmio_uart_tx #(
        .g_ADDR_WIDTH   (11),
        .g_DATA_WIDTH   (9),
        .g_BASE_ADDR    (BaseAddr),
        .g_CLKS_PER_BIT (Clks),
        .g_FIFO_DEPTH   (4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_we   (we),
        .i_re   (re),
        .i_addr (addr),
        .i_data (wdata),
        .o_data (rdata),
        .o_tx   (tx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] mdl_fifo[$];
    logic [7:0] exp_q[$];
    bit         mdl_ovf   = 1'b0;
    int         cyc       = 0;
    int         last_pop  = -1000;
    int         accepts   = 0;
    logic [8:0] exp_rdata = '0;

    // A frame occupies the line for FrameCycles cycles from the pop; the next byte may be
    // popped on the cycle the previous stop bit ends, or any later cycle.
    initial begin : model
        bit         sel, m_wr, m_rd, busy, pop;
        int         cnt;
        logic [8:0] status;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mdl_fifo.delete();
                exp_q.delete();
                mdl_ovf   = 1'b0;
                last_pop  = -1000;
                exp_rdata = '0;
            end else begin
                cyc++;
                sel    = en && (addr[10:2] == BaseAddr[10:2]);
                m_wr   = sel && we && !re;
                m_rd   = sel && re && !we;
                cnt    = mdl_fifo.size();
                busy   = (cyc <= last_pop + FrameCycles);
                status = {mdl_ovf, 2'b00, 3'(cnt), cnt == 0, cnt == Depth, busy};
                exp_rdata = (m_rd && addr[1:0] == 2'd1) ? status : 9'h000;
                pop = (cnt > 0) && (cyc >= last_pop + FrameCycles);
                if (pop) begin
                    void'(mdl_fifo.pop_front());
                    last_pop = cyc;
                end
                if (m_wr && addr[1:0] == 2'd0) begin
                    if (cnt < Depth || pop) begin
                        mdl_fifo.push_back(wdata[7:0]);
                        exp_q.push_back(wdata[7:0]);
                        accepts++;
                    end else begin
                        mdl_ovf = 1'b1;
                    end
                end else if (m_wr && addr[1:0] == 2'd2 && wdata[0]) begin
                    mdl_ovf = 1'b0;
                end
            end
        end
    end

    // Line monitor: samples every cycle mid-way between edges.
    int   ncyc = 0;
    int   starts[$];
    bit   mon_act = 1'b0;
    int   mon_idx = 0;
    logic [9:0] mon_bits = '0;
    bit   mon_glitch = 1'b0;

    initial begin : monitor
        int b;
        forever begin
            @(negedge clk);
            ncyc++;
            check("o_data", int'(rdata), int'(exp_rdata));
            if (rst) begin
                check("tx_during_reset", int'(tx), 1);
                mon_act = 1'b0;
            end else if (!mon_act) begin
                if (tx == 1'b0) begin
                    mon_act    = 1'b1;
                    mon_idx    = 1;
                    mon_bits   = '0;
                    mon_glitch = 1'b0;
                    starts.push_back(ncyc);
                end
            end else begin
                b = mon_idx / int'(Clks);
                if (mon_idx % int'(Clks) == 0) begin
                    mon_bits[b] = tx;
                end else if (tx != mon_bits[b]) begin
                    mon_glitch = 1'b1;
                end
                mon_idx++;
                if (mon_idx == FrameCycles) begin
                    mon_act = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", int'(mon_bits[8:1]), -1);
                    end else begin
                        check("frame_byte", int'(mon_bits[8:1]), int'(exp_q.pop_front()));
                    end
                    check("frame_stop_and_bit_width", int'({mon_bits[9], mon_glitch}), 2);
                end
            end
        end
    end

    task automatic bus(input bit e, input bit w, input bit r, input logic [10:0] a,
                       input logic [8:0] d);
        en    = e;
        we    = w;
        re    = r;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int s0, a0, n, pick;
        logic [10:0] ra;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        bus(1, 0, 1, 11'h7F1, 9'h000);
        idle(2);

        // Single frame of 0x55, STATUS read while it is on the line
        bus(1, 1, 0, 11'h7F0, 9'h055);
        idle(6);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        idle(FrameCycles);

        // Back-to-back writes from idle: frames must abut with no gap
        s0 = starts.size();
        a0 = accepts;
        for (int i = 0; i < 5; i++) begin
            bus(1, 1, 0, 11'h7F0, 9'($urandom_range(0, 255)));
        end
        idle(5 * FrameCycles + 10);
        check("b2b_frame_count", starts.size() - s0, accepts - a0);
        for (int i = s0 + 1; i < starts.size(); i++) begin
            check("b2b_gap", starts[i] - starts[i-1], FrameCycles);
        end

        // Overflow while the first frame is in its data bits
        bus(1, 1, 0, 11'h7F0, 9'h0A5);
        idle(Clks + 4);
        for (int i = 0; i < 6; i++) begin
            bus(1, 1, 0, 11'h7F0, 9'($urandom_range(0, 511)));
        end
        bus(1, 0, 1, 11'h7F1, 9'h000);
        bus(1, 1, 0, 11'h7F2, 9'h000);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        bus(1, 1, 0, 11'h7F2, 9'h001);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        idle(7 * FrameCycles);

        // Decode corners: out-of-window, reserved, read-zero offsets, strobe qualifiers
        bus(1, 0, 1, 11'h7F4, 9'h000);
        bus(1, 1, 0, 11'h7F4, 9'h0FF);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        bus(1, 0, 1, 11'h7F0, 9'h000);
        bus(1, 0, 1, 11'h7F2, 9'h000);
        bus(1, 0, 1, 11'h7F3, 9'h000);
        bus(1, 1, 1, 11'h7F0, 9'h033);
        bus(0, 1, 0, 11'h7F0, 9'h044);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        bus(1, 1, 0, 11'h7F0, 9'h1AB);
        idle(FrameCycles + 4);

        // Reset in the middle of data bit 3
        bus(1, 1, 0, 11'h7F0, 9'h0C3);
        idle(1 + Clks + 3 * Clks + 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bus(1, 0, 1, 11'h7F1, 9'h000);
        idle(1);
        bus(1, 1, 0, 11'h7F0, 9'h03C);
        idle(FrameCycles + 4);

        // Randomised traffic around the window
        for (int i = 0; i < 400; i++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0, 1, 2: ra = 11'h7F0;
                3:       ra = 11'h7F1;
                4:       ra = 11'h7F2;
                5:       ra = 11'h7F3;
                default: ra = 11'($urandom_range(0, 2047));
            endcase
            bus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ra, 9'($urandom_range(0, 511)));
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(0, 30)));
            end
        end

        n = 0;
        while ((exp_q.size() != 0 || mon_act) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_within_budget", int'(n < 3000), 1);
        idle(FrameCycles);
        bus(1, 0, 1, 11'h7F1, 9'h000);
        idle(3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
